// File: rtl/regs_wb_sched.sv
// regs_wb_sched: writeback port scheduler with aging and per-register pending-write scoreboard
module regs_wb_sched #(
  parameter int DW = 64,
  parameter int AGE_LIMIT = 4,
  parameter int CNT_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2:0]          req_valid_i,
  input  logic [2:0][3:0]     req_reg_i,
  input  logic [2:0][DW-1:0]  req_data_i,
  output logic [2:0]          req_ready_o,
  input  logic                rsv_valid_i,
  input  logic [3:0]          rsv_reg_i,
  output logic                rsv_ready_o,
  input  logic [3:0]          qry_a_i,
  input  logic [3:0]          qry_b_i,
  output logic                busy_a_o,
  output logic                busy_b_o,
  output logic [3:0]          dstA,
  output logic [DW-1:0]       dstA_data,
  output logic [3:0]          dstB,
  output logic [DW-1:0]       dstB_data
);
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [AW-1:0] age;
  logic [CNT_W-1:0] cnt [16];
  logic [2:0] ready;
  logic [3:0] na, nb;
  logic [DW-1:0] da, db;
  logic [1:0] n, sel;
  logic promote;
  assign promote = age == AW'(AGE_LIMIT);
  // Walk requesters in priority order; register 4'hf needs no port, and a
  // second write to the register already on port A waits for a later cycle.
  always_comb begin
    ready = '0;
    na = 4'hf;
    nb = 4'hf;
    da = '0;
    db = '0;
    n = '0;
    sel = '0;
    for (int k = 0; k < 3; k++) begin
      sel = promote ? (k == 0 ? 2'd2 : 2'(k - 1)) : 2'(k);
      if (req_valid_i[sel] && !rst_i) begin
        if (req_reg_i[sel] == 4'hf) ready[sel] = 1'b1;
        else if (n == 2'd0) begin
          na = req_reg_i[sel];
          da = req_data_i[sel];
          n = 2'd1;
          ready[sel] = 1'b1;
        end else if (n == 2'd1 && req_reg_i[sel] != na) begin
          nb = req_reg_i[sel];
          db = req_data_i[sel];
          n = 2'd2;
          ready[sel] = 1'b1;
        end
      end
    end
  end
  assign req_ready_o = ready;
  // Entry 15 is never updated after reset, so "no register" is never busy and never full.
  assign rsv_ready_o = !rst_i && (cnt[rsv_reg_i] != '1);
  assign busy_a_o = cnt[qry_a_i] != '0;
  assign busy_b_o = cnt[qry_b_i] != '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dstA <= 4'hf;
      dstB <= 4'hf;
      dstA_data <= '0;
      dstB_data <= '0;
      age <= '0;
      for (int r = 0; r < 16; r++) cnt[r] <= '0;
    end else begin
      dstA <= na;
      dstB <= nb;
      dstA_data <= da;
      dstB_data <= db;
      age <= (req_valid_i[2] && !ready[2]) ? (promote ? age : age + 1'b1) : '0;
      for (int r = 0; r < 15; r++) begin
        if (rsv_valid_i && rsv_ready_o && rsv_reg_i == 4'(r) && dstA != 4'(r) && dstB != 4'(r))
          cnt[r] <= cnt[r] + 1'b1;
        else if (!(rsv_valid_i && rsv_ready_o && rsv_reg_i == 4'(r)) && (dstA == 4'(r) || dstB == 4'(r)) && cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regs_wb_sched.sv
// tb_regs_wb_sched: directed scenarios plus randomized traffic against a queue-based reference model
module tb_regs_wb_sched;
  localparam int AGE = 4;
  logic clk = 0;
  logic rst;
  logic [2:0] valid;
  logic [2:0][3:0] rreg;
  logic [2:0][63:0] rdata;
  logic [2:0] ready;
  logic rsv_valid, rsv_ready, busy_a, busy_b;
  logic [3:0] rsv_reg, qa, qb, dsta, dstb;
  logic [63:0] dstad, dstbd;
  int errors = 0, checks = 0;

  int m_cnt[15];
  int m_age;
  logic [3:0] m_da, m_db;
  logic [63:0] m_dad, m_dbd;
  logic [2:0] e_ready;
  logic [3:0] e_na, e_nb;
  logic [63:0] e_dad, e_dbd;
  logic e_rsv_ready, e_busy_a, e_busy_b;

  regs_wb_sched dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_reg_i(rreg), .req_data_i(rdata),
    .req_ready_o(ready), .rsv_valid_i(rsv_valid), .rsv_reg_i(rsv_reg), .rsv_ready_o(rsv_ready),
    .qry_a_i(qa), .qry_b_i(qb), .busy_a_o(busy_a), .busy_b_o(busy_b),
    .dstA(dsta), .dstA_data(dstad), .dstB(dstb), .dstB_data(dstbd)
  );

  always #5 clk = ~clk;

  task automatic model_eval;
    int ord[3];
    logic [3:0] g[$];
    e_ready = '0;
    e_na = 4'hf;
    e_nb = 4'hf;
    e_dad = '0;
    e_dbd = '0;
    if (m_age == AGE) begin ord[0] = 2; ord[1] = 0; ord[2] = 1; end
    else begin ord[0] = 0; ord[1] = 1; ord[2] = 2; end
    if (!rst) foreach (ord[k]) begin
      int i;
      bit dup;
      i = ord[k];
      dup = 0;
      foreach (g[j]) if (g[j] == rreg[i]) dup = 1;
      if (valid[i] && rreg[i] == 4'hf) e_ready[i] = 1;
      else if (valid[i] && g.size() < 2 && !dup) begin
        if (g.size() == 0) begin e_na = rreg[i]; e_dad = rdata[i]; end
        else begin e_nb = rreg[i]; e_dbd = rdata[i]; end
        g.push_back(rreg[i]);
        e_ready[i] = 1;
      end
    end
    e_rsv_ready = !rst && (rsv_reg == 4'hf || m_cnt[rsv_reg] < 3);
    e_busy_a = qa != 4'hf && m_cnt[qa] > 0;
    e_busy_b = qb != 4'hf && m_cnt[qb] > 0;
  endtask

  task automatic model_clock;
    if (rst) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_age = 0;
      m_da = 4'hf;
      m_db = 4'hf;
      m_dad = '0;
      m_dbd = '0;
    end else begin
      foreach (m_cnt[r]) begin
        int d;
        d = 0;
        if (rsv_valid && e_rsv_ready && rsv_reg == 4'(r)) d++;
        if (m_da == 4'(r) || m_db == 4'(r)) d--;
        m_cnt[r] = (m_cnt[r] + d < 0) ? 0 : m_cnt[r] + d;
      end
      m_age = (valid[2] && !e_ready[2]) ? ((m_age + 1 > AGE) ? AGE : m_age + 1) : 0;
      m_da = e_na;
      m_db = e_nb;
      m_dad = e_dad;
      m_dbd = e_dbd;
    end
  endtask

  task automatic tick;
    model_eval;
    @(posedge clk);
    model_clock;
    #1;
  endtask

  task automatic idle;
    valid = '0;
    rsv_valid = 0;
    rsv_reg = 4'hf;
    qa = 4'hf;
    qb = 4'hf;
  endtask

  task automatic test_reset;
    rst = 1;
    idle;
    valid = 3'b111;
    rreg[0] = 1; rreg[1] = 2; rreg[2] = 3;
    rdata = '0;
    rsv_valid = 1;
    rsv_reg = 1;
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_age = 0;
    tick;
    tick;
    checks++; if (ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", ready); end
    checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL reset_rsv_ready got=%b exp=0", rsv_ready); end
    checks++; if (dsta !== 4'hf || dstb !== 4'hf) begin errors++; $display("FAIL reset_dst got=%h/%h exp=f/f", dsta, dstb); end
    checks++; if (dstad !== 64'd0 || dstbd !== 64'd0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", dstad, dstbd); end
    rst = 0;
    idle;
    tick;
  endtask

  task automatic test_reserve_write;
    rsv_valid = 1; rsv_reg = 3; qa = 3;
    #1;
    checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL rw_rsv_ready got=%b exp=1", rsv_ready); end
    tick;
    rsv_valid = 0;
    valid = 3'b001; rreg[0] = 3; rdata[0] = 64'h1111;
    #1;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rw_busy_after_rsv got=%b exp=1", busy_a); end
    checks++; if (ready !== 3'b001) begin errors++; $display("FAIL rw_ready got=%b exp=001", ready); end
    tick;
    valid = 0;
    #1;
    checks++; if (dsta !== 4'd3 || dstad !== 64'h1111) begin errors++; $display("FAIL rw_dstA got=%h/%h exp=3/1111", dsta, dstad); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rw_busy_before_commit got=%b exp=1", busy_a); end
    tick;
    checks++; if (busy_a !== 1'b0 || dsta !== 4'hf) begin errors++; $display("FAIL rw_after_commit got busy=%b dstA=%h exp busy=0 dstA=f", busy_a, dsta); end
    idle;
  endtask

  task automatic test_dual_grant;
    valid = 3'b111;
    rreg[0] = 1; rreg[1] = 2; rreg[2] = 4;
    rdata[0] = 64'hA1; rdata[1] = 64'hB2; rdata[2] = 64'hC4;
    #1;
    checks++; if (ready !== 3'b011) begin errors++; $display("FAIL dual_ready got=%b exp=011", ready); end
    tick;
    valid = 3'b100;
    #1;
    checks++; if (dsta !== 4'd1 || dstb !== 4'd2 || dstad !== 64'hA1 || dstbd !== 64'hB2)
      begin errors++; $display("FAIL dual_ports got=%h/%h %h/%h exp=1/a1 2/b2", dsta, dstad, dstb, dstbd); end
    checks++; if (ready !== 3'b100) begin errors++; $display("FAIL dual_ready2 got=%b exp=100", ready); end
    tick;
    valid = 0;
    #1;
    checks++; if (dsta !== 4'd4 || dstb !== 4'hf || dstad !== 64'hC4) begin errors++; $display("FAIL dual_req2 got=%h/%h/%h exp=4/f/c4", dsta, dstb, dstad); end
    tick;
  endtask

  task automatic test_conflict;
    valid = 3'b011;
    rreg[0] = 5; rreg[1] = 5;
    rdata[0] = 64'hAA; rdata[1] = 64'hBB;
    #1;
    checks++; if (ready !== 3'b001) begin errors++; $display("FAIL conflict_ready got=%b exp=001", ready); end
    tick;
    valid = 3'b010;
    #1;
    checks++; if (dsta !== 4'd5 || dstad !== 64'hAA || dstb !== 4'hf) begin errors++; $display("FAIL conflict_first got=%h/%h/%h exp=5/aa/f", dsta, dstad, dstb); end
    checks++; if (ready !== 3'b010) begin errors++; $display("FAIL conflict_ready2 got=%b exp=010", ready); end
    tick;
    valid = 0;
    #1;
    checks++; if (dsta !== 4'd5 || dstad !== 64'hBB) begin errors++; $display("FAIL conflict_second got=%h/%h exp=5/bb", dsta, dstad); end
    tick;
  endtask

  task automatic test_aging;
    valid = 3'b111;
    rreg[0] = 1; rreg[1] = 2; rreg[2] = 6;
    rdata[2] = 64'h66;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (ready !== 3'b011) begin errors++; $display("FAIL aging_wait%0d got=%b exp=011", c, ready); end
      tick;
    end
    #1;
    checks++; if (ready !== 3'b101) begin errors++; $display("FAIL aging_promote got=%b exp=101", ready); end
    tick;
    #1;
    checks++; if (dsta !== 4'd6 || dstb !== 4'd1 || dstad !== 64'h66) begin errors++; $display("FAIL aging_ports got=%h/%h/%h exp=6/1/66", dsta, dstb, dstad); end
    checks++; if (ready !== 3'b011) begin errors++; $display("FAIL aging_cleared got=%b exp=011", ready); end
    valid = 0;
    tick;
    tick;
  endtask

  task automatic test_saturation;
    rsv_valid = 1; rsv_reg = 7; qa = 7;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL sat_rsv%0d got=%b exp=1", c, rsv_ready); end
      tick;
    end
    #1;
    checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL sat_full got=%b exp=0", rsv_ready); end
    tick;
    rsv_valid = 0;
    valid = 3'b001; rreg[0] = 7; rdata[0] = 64'h77;
    tick;
    valid = 0;
    tick;
    valid = 3'b001;
    tick;
    valid = 0;
    rsv_valid = 1;
    #1;
    checks++; if (dsta !== 4'd7 || rsv_ready !== 1'b1) begin errors++; $display("FAIL sat_same_edge got dstA=%h rdy=%b exp dstA=7 rdy=1", dsta, rsv_ready); end
    tick;
    #1;
    checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL sat_unchanged got=%b exp=1", rsv_ready); end
    tick;
    #1;
    checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL sat_refull got=%b exp=0", rsv_ready); end
    tick;
    rsv_valid = 0;
  endtask

  task automatic test_mid_reset;
    qa = 7; qb = 8;
    valid = 3'b011; rreg[0] = 8; rreg[1] = 9;
    tick;
    #1;
    checks++; if (dsta !== 4'd8 || dstb !== 4'd9 || busy_a !== 1'b1) begin errors++; $display("FAIL mrst_pre got=%h/%h busy=%b exp=8/9/1", dsta, dstb, busy_a); end
    rst = 1; rsv_valid = 1; rsv_reg = 2;
    #1;
    checks++; if (ready !== 3'b000 || rsv_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready got=%b/%b exp=000/0", ready, rsv_ready); end
    tick;
    #1;
    checks++; if (dsta !== 4'hf || dstb !== 4'hf || busy_a !== 1'b0 || busy_b !== 1'b0)
      begin errors++; $display("FAIL mrst_post got=%h/%h busy=%b%b exp=f/f busy=00", dsta, dstb, busy_a, busy_b); end
    rst = 0;
    idle;
    tick;
  endtask

  function automatic logic [3:0] pick;
    int r;
    r = $urandom_range(0, 7);
    return (r == 7) ? 4'hf : 4'(r);
  endfunction

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(valid[i] && !e_ready[i])) begin
          valid[i] = $urandom_range(0, 1);
          rreg[i] = pick();
          rdata[i] = {$urandom, $urandom};
        end
      end
      rst = ($urandom_range(0, 49) == 0);
      rsv_valid = $urandom_range(0, 1);
      rsv_reg = pick();
      qa = pick();
      qb = pick();
      #1;
      model_eval;
      checks++; if (ready !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ready, e_ready); end
      checks++; if (rsv_ready !== e_rsv_ready) begin errors++; $display("FAIL rnd_rsv_ready c=%0d got=%b exp=%b", c, rsv_ready, e_rsv_ready); end
      checks++; if (busy_a !== e_busy_a || busy_b !== e_busy_b) begin errors++; $display("FAIL rnd_busy c=%0d got=%b%b exp=%b%b", c, busy_a, busy_b, e_busy_a, e_busy_b); end
      tick;
      checks++; if (dsta !== m_da || dstb !== m_db) begin errors++; $display("FAIL rnd_dst c=%0d got=%h/%h exp=%h/%h", c, dsta, dstb, m_da, m_db); end
      if (m_da != 4'hf) begin
        checks++; if (dstad !== m_dad) begin errors++; $display("FAIL rnd_dataA c=%0d got=%h exp=%h", c, dstad, m_dad); end
      end
      if (m_db != 4'hf) begin
        checks++; if (dstbd !== m_dbd) begin errors++; $display("FAIL rnd_dataB c=%0d got=%h exp=%h", c, dstbd, m_dbd); end
      end
    end
    rst = 0;
    idle;
    tick;
  endtask

  initial begin
    rreg = '0;
    rdata = '0;
    e_ready = '0;
    test_reset;
    test_reserve_write;
    test_dual_grant;
    test_conflict;
    test_aging;
    test_saturation;
    test_mid_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regs_wb_sched.md
Name: regs_wb_sched

Overview:
Writeback scheduler and scoreboard in front of the two-write-port register file (15 x 64-bit, index 4'hf = "no register"). Three writeback requesters (M-stage, W-stage, multiply/divide unit) share write ports A and B under fixed priority plus anti-starvation aging. A per-register pending-write counter gives decode a busy indication for its two source operands.

Parameters:
DW, 64, register data width
AGE_LIMIT, 4, wait cycles after which requester 2 is promoted to top priority
CNT_W, 2, width of per-register pending-write counter (max outstanding = 2^CNT_W-1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  3  per-requester write request (bit 0 = highest base priority)
req_reg_i  in  3x4  destination register per requester
req_data_i  in  3xDW  write data per requester
req_ready_o  out  3  accept, combinational; transfer when valid & ready
rsv_valid_i  in  1  decode reserves destination register
rsv_reg_i  in  4  register being reserved
rsv_ready_o  out  1  reservation accepted (counter not saturated)
qry_a_i  in  4  decode source A register
qry_b_i  in  4  decode source B register
busy_a_o  out  1  source A has pending write
busy_b_o  out  1  source B has pending write
dstA  out  4  register file port A destination (4'hf = idle)
dstA_data  out  DW  port A data
dstB  out  4  register file port B destination
dstB_data  out  DW  port B data

Behaviour:
- One clock clk_i; reset rst_i is synchronous and active-high.
- Reset: dstA/dstB = 4'hf, data = 0, all pending counters = 0, age counter = 0; req_ready_o = 0, rsv_ready_o = 0 while rst_i high.
- Request with req_reg = 4'hf: ready immediately, consumes no port, no counter effect.
- Grant order each cycle: requester 2 first if age == AGE_LIMIT, else 0, 1, 2. Up to two requests granted; first grant -> port A, second -> port B.
- Same-register conflict in one cycle: only the higher-ordered request granted; the other stays not-ready and writes a later cycle (its data is final value).
- Ungranted requester must hold valid/reg/data stable until ready.
- Latency: granted write appears on dstA/dstB on the next edge (registered), committed by the register file on the following edge. Non-granted port drives 4'hf.
- Age: increments each cycle req_valid_i[2] is high and not granted, saturates at AGE_LIMIT; clears when requester 2 granted or not valid.
- Pending counter per register 0..14: +1 on accepted reservation; -1 on the edge where that register is on dstA or dstB (i.e. the register-file commit edge); both on same edge -> unchanged. dstA and dstB never target the same register.
- rsv_ready_o = 0 when target counter is at max; reservation of 4'hf always accepted, no effect.
- busy_x_o = (counter[qry_x] != 0), combinational; query of 4'hf never busy.
- Decrement of a zero counter (write with no reservation) saturates at 0.
- Reset mid-operation discards in-flight registered writes and all counters.

Test Plan:
- Reserve r3, then requester 0 writes r3=0x1111 -> dstA=3 / 0x1111 one cycle after accept; busy_a (qry_a=3) high until that commit edge, low after.
- Requesters 0,1,2 valid on r1,r2,r4 -> ready=3'b011, dstA=1, dstB=2; next cycle requester 2 -> dstA=4.
- Requesters 0 and 1 both write r5 (0xAA, 0xBB) -> cycle 1 only req0 ready, dstA=5/0xAA; cycle 2 dstA=5/0xBB.
- Requesters 0,1 valid every cycle, requester 2 waiting -> on 5th cycle (age=4) requester 2 granted on port A, age returns 0.
- Reserve r7 three times -> counter 3, fourth rsv_ready_o=0; reserve and commit of r7 same cycle -> counter unchanged.
- Assert rst_i with writes queued and counters nonzero -> next cycle dstA=dstB=4'hf, all busy low, ready low during reset.
